// File: rtl/uart_inst_rx.sv
// uart_inst_rx: decodes ASCII hex pairs into 8-bit seq instructions, buffers them and issues gap-paced strobes.
// Optional saturating error counter is built when UART_INST_RX_ERRCNT_EN is defined.
module uart_inst_rx #(
   parameter int FIFO_AW    = 2,
   parameter int GAP_CYCLES = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [7:0]         i_rx_data,
   input  logic               i_rx_valid,
   output logic [7:0]         o_inst,
   output logic               o_inst_valid,
   output logic [FIFO_AW:0]   o_fifo_cnt,
   output logic               o_overflow,
   output logic               o_err,
   output logic [7:0]         o_err_cnt
);
   localparam int DEPTH = 1 << FIFO_AW;
   localparam int CW = FIFO_AW + 1;
   localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
   typedef enum logic {IDLE, HAVE_HI} state_t;
   state_t state;
   logic [3:0] hi, nib;
   logic [7:0] mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
   logic [GW-1:0] gc;
   logic is_dig, is_hex, is_sep, bad, push, pop, full, wr;
   assign is_dig = i_rx_data inside {[8'h30:8'h39]};
   assign is_hex = is_dig || (i_rx_data inside {[8'h41:8'h46], [8'h61:8'h66]});
   assign is_sep = i_rx_data inside {8'h0D, 8'h0A, 8'h20};
   // letters A-F/a-f all carry 1..6 in their low nibble
   assign nib = is_dig ? i_rx_data[3:0] : i_rx_data[3:0] + 4'd9;
   assign bad = i_rx_valid && (state == HAVE_HI ? !is_hex : !(is_hex || is_sep));
   assign push = i_rx_valid && state == HAVE_HI && is_hex;
   assign full = o_fifo_cnt == CW'(DEPTH);
   assign pop = gc == '0 && o_fifo_cnt != '0;
   assign wr = push && (!full || pop);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         hi <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         gc <= '0;
         o_fifo_cnt <= '0;
         o_inst <= '0;
         o_inst_valid <= 1'b0;
         o_overflow <= 1'b0;
         o_err <= 1'b0;
      end else begin
         if (i_rx_valid) begin
            state <= (state == IDLE && is_hex) ? HAVE_HI : IDLE;
            if (state == IDLE) hi <= nib;
         end
         o_err <= bad;
         if (wr) wr_ptr <= wr_ptr + FIFO_AW'(1);
         if (pop) rd_ptr <= rd_ptr + FIFO_AW'(1);
         o_fifo_cnt <= o_fifo_cnt + CW'(wr) - CW'(pop);
         if (push && !wr) o_overflow <= 1'b1;
         o_inst_valid <= pop;
         if (pop) o_inst <= mem[rd_ptr];
         gc <= pop ? GW'(GAP_CYCLES - 1) : gc - GW'(gc != '0);
      end
   always_ff @(posedge clk)
      if (wr) mem[wr_ptr] <= {hi, nib};
`ifdef UART_INST_RX_ERRCNT_EN
   always_ff @(posedge clk or posedge rst)
      if (rst) o_err_cnt <= '0;
      else if (o_err && o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
`else
   assign o_err_cnt = 8'h00;
`endif
endmodule

// File: tb/tb_uart_inst_rx.sv
// tb_uart_inst_rx: randomized and directed stimulus against an event-scheduling reference model with a scoreboard.
module tb_uart_inst_rx;
   localparam int AW = 2, GAP = 16, DEPTH = 1 << AW;
   logic clk = 0, rst = 1;
   logic [7:0] i_rx_data = 0;
   logic i_rx_valid = 0;
   logic [7:0] o_inst, o_err_cnt;
   logic o_inst_valid, o_overflow, o_err;
   logic [AW:0] o_fifo_cnt;
   uart_inst_rx #(.FIFO_AW(AW), .GAP_CYCLES(GAP)) dut (
      .clk(clk), .rst(rst), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
      .o_inst(o_inst), .o_inst_valid(o_inst_valid), .o_fifo_cnt(o_fifo_cnt),
      .o_overflow(o_overflow), .o_err(o_err), .o_err_cnt(o_err_cnt));
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   int checks = 0, errors = 0;
   typedef struct {logic [7:0] d; int e;} exp_t;
   exp_t exp_q[$];
   int err_q[$], pops[$];
   int last_p = -100000, m_errs = 0;
   bit m_hi_v = 0, m_ovf = 0;
   logic [3:0] m_hi = 0;

   task automatic chk(string name, int act, int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic int hexval(logic [7:0] c);
      if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
      if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
      if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
      return -1;
   endfunction

   function automatic int exp_err_cnt();
`ifdef UART_INST_RX_ERRCNT_EN
      return m_errs;
`else
      return 0;
`endif
   endfunction

   task automatic m_err(int t);
      err_q.push_back(t);
      if (m_errs < 255) m_errs++;
   endtask

   // an instruction written at edge t is popped at the earliest edge allowed by both the write and the gap
   task automatic m_push(logic [7:0] d, int t);
      int p;
      while (pops.size() > 0 && pops[0] < t) void'(pops.pop_front());
      if (pops.size() == DEPTH && pops[0] != t) m_ovf = 1;
      else begin
         p = (t + 1 > last_p + GAP) ? t + 1 : last_p + GAP;
         last_p = p;
         pops.push_back(p);
         exp_q.push_back('{d, p});
      end
   endtask

   task automatic model(logic [7:0] c, int t);
      int v;
      bit sep;
      v = hexval(c);
      sep = c == 8'h0D || c == 8'h0A || c == 8'h20;
      if (!m_hi_v) begin
         if (v >= 0) begin m_hi = v[3:0]; m_hi_v = 1; end
         else if (!sep) m_err(t);
      end else begin
         m_hi_v = 0;
         if (v < 0) m_err(t);
         else m_push({m_hi, v[3:0]}, t);
      end
   endtask

   task automatic idle(int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic send(logic [7:0] c);
      i_rx_data = c;
      i_rx_valid = 1;
      model(c, cyc + 1);
      @(posedge clk);
      #1 i_rx_valid = 0;
   endtask

   task automatic send_str(string s);
      foreach (s[i]) send(s[i]);
   endtask

   task automatic do_reset();
      rst = 1;
      exp_q.delete(); err_q.delete(); pops.delete();
      last_p = -100000; m_hi_v = 0; m_ovf = 0; m_errs = 0;
      #2;
      chk("rst_inst_valid", o_inst_valid, 0);
      chk("rst_inst", o_inst, 0);
      chk("rst_fifo_cnt", o_fifo_cnt, 0);
      chk("rst_overflow", o_overflow, 0);
      chk("rst_err", o_err, 0);
      chk("rst_err_cnt", o_err_cnt, 0);
      idle(2);
      rst = 0;
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() > 0 || err_q.size() > 0) && n < 5000) begin idle(1); n++; end
      chk("drain_pending", exp_q.size() + err_q.size(), 0);
      idle(GAP + 3);
      chk("overflow", o_overflow, m_ovf);
      chk("err_cnt", o_err_cnt, exp_err_cnt());
      chk("fifo_empty", o_fifo_cnt, 0);
   endtask

   always @(negedge clk) begin : mon
      exp_t e;
      if (!rst) begin
         if (o_inst_valid) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_inst: got %0h at cycle %0d, expected no pulse", o_inst, cyc);
            end else begin
               e = exp_q.pop_front();
               chk("inst_data", o_inst, e.d);
               chk("inst_cycle", cyc, e.e);
            end
         end else if (exp_q.size() > 0 && exp_q[0].e < cyc) begin
            e = exp_q.pop_front();
            checks++; errors++;
            $display("FAIL missing_inst: got none by cycle %0d, expected %0h at cycle %0d", cyc, e.d, e.e);
         end
         if (o_err) begin
            if (err_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_err: got pulse at cycle %0d, expected none", cyc);
            end else chk("err_cycle", cyc, err_q.pop_front());
         end else if (err_q.size() > 0 && err_q[0] < cyc) begin
            checks++; errors++;
            $display("FAIL missing_err: got none, expected pulse at cycle %0d", err_q.pop_front());
         end
      end
   end

   initial begin
      int np;
      @(posedge clk); #1;
      do_reset();
      send("3"); idle(20); send("A");
      drain();
      chk("t1_inst", o_inst, 8'h3A);
      send("c"); send("5"); send(8'h0D); send(8'h0A); send("F"); send("F");
      drain();
      chk("t2_inst", o_inst, 8'hFF);
      send("G"); send("1"); send(" "); send("2");
      drain();
`ifdef UART_INST_RX_ERRCNT_EN
      chk("t3_err_cnt", o_err_cnt, 2);
`else
      chk("t3_err_cnt", o_err_cnt, 0);
`endif
      do_reset();
      send_str("000102030405");
      drain();
      chk("t4_overflow", o_overflow, 1);
      idle(50);
      chk("t4_overflow_sticky", o_overflow, 1);
      do_reset();
      send_str("1011121314");
      np = 0;
      foreach (pops[i]) if (np == 0 && pops[i] >= cyc + 2) np = pops[i];
      idle(np - 2 - cyc);
      send("9"); send("9");
      chk("t5_fifo_cnt", o_fifo_cnt, 4);
      chk("t5_overflow", o_overflow, 0);
      drain();
      do_reset();
      send_str("11223344"); send("7");
      do_reset();
      send_str("7E");
      drain();
      chk("t6_inst", o_inst, 8'h7E);
      do_reset();
      repeat (260) send("Z");
      drain();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         string hs = "0123456789abcdefABCDEF";
         int r = $urandom_range(0, 9);
         if (r < 6) send(hs[$urandom_range(0, 21)]);
         else if (r == 6) send(8'h20);
         else if (r == 7) send($urandom_range(0, 1) ? 8'h0D : 8'h0A);
         else send(8'($urandom_range(0, 255)));
         if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 40));
      end
      drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
